dose_scheduler: RTL and testbench
=================================

Name: dose_scheduler

Overview:
- Parametrised successor to the fixed morning/afternoon/evening dispense logic.
- Holds a programmable table of NUM_SLOTS dose times with per-channel pill counts for NUM_CH compartments.
- Compares the table against the time-of-day counters and sequences dispense handshakes with the compartment drivers, one channel at a time.
- Raises an alarm until the patient acknowledges or a timeout expires; sits between the clock counters and the dispenser/alarm blocks.

Parameters:
NUM_CH, 2, number of compartments/dispense channels (1..8)
NUM_SLOTS, 3, number of programmable dose times (1..8)
CNT_W, 3, width of per-channel pill count per slot
ACK_TIMEOUT_S, 900, seconds the alarm waits for taken_ack before declaring a miss

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_sec  in  1  one-cycle pulse per second, coincident with the seconds update
hours  in  5  time of day, 0..23
minutes  in  6  0..59
seconds  in  6  0..59
cfg_we  in  1  one-cycle table write strobe
cfg_slot  in  clog2(NUM_SLOTS) (min 1)  slot index
cfg_ch  in  clog2(NUM_CH) (min 1)  channel index for count write
cfg_en  in  1  slot enable
cfg_hour  in  5  slot hour
cfg_min  in  6  slot minute
cfg_count  in  CNT_W  pills for (cfg_slot, cfg_ch)
dispense_req  out  NUM_CH  one-hot request to compartment driver
dispense_ack  in  NUM_CH  driver completion, one pulse or level per pill
alarm  out  1  alarm enable to audio block
taken_ack  in  1  one-cycle user acknowledge (debounced upstream)
busy  out  1  high whenever state is not IDLE
missed_cnt  out  8  saturating missed-dose count (see optional feature)

Behaviour:
- Reset: table cleared (all enables 0, times 0, counts 0). All outputs 0; state IDLE; pending flag 0.
- Config write: on cfg_we, write slot enable/hour/min and count[cfg_slot][cfg_ch] in the same cycle. Accepted in any state; affects only future triggers.
- Trigger: on tick_sec with seconds==0, any enabled slot whose hour and minute match the inputs fires. If several slots match, the lowest index wins and the others are ignored. Out-of-range table values never match.
- IDLE: on trigger (or when pending==1), latch that slot's NUM_CH counts into remaining[] (next cycle) and go to DISPENSE with ch=0. Clear pending.
- DISPENSE:
  - If remaining[ch]==0, advance ch in the next cycle.
  - Otherwise assert dispense_req[ch]. Hold it until dispense_ack[ch] is sampled high.
  - On that cycle, decrement remaining[ch]. req goes low the next cycle and stays low for at least one cycle before re-asserting.
  - Acks on channels other than ch are ignored.
  - After ch==NUM_CH-1 is done, go to ALARM. If every count is zero, go straight from DISPENSE to ALARM.
- ALARM:
  - alarm=1; the timer clears on entry and increments on tick_sec.
  - On taken_ack go to IDLE; alarm drops the next cycle.
  - When the timer reaches ACK_TIMEOUT_S, increment missed_cnt (saturates at 255) and go to IDLE.
  - If taken_ack and the timeout occur in the same cycle, the acknowledge wins (no miss counted).
- Trigger while busy: set pending (one deep). Further triggers while pending==1 are dropped.
- Latency: trigger on cycle t gives dispense_req high at t+2 when the first channel count is nonzero.
- Reset mid-operation: req and alarm drop in the next cycle; nothing resumes.

Optional Feature:
DOSE_MISS_CNT_EN
- Defined: the missed_cnt register and its saturation logic are present, as above.
- Undefined: missed_cnt is tied to 0. The timeout still returns the FSM to IDLE.

Decomposition:
- Package dose_pkg: state enum (IDLE, DISPENSE, ALARM), HOUR_W=5, MIN_W=6, SEC_W=6, MISS_W=8, and the timeout-counter width function.
- One sub-module, dose_slot_match: a combinational priority compare of the table against the time, returning hit and index.

Test Plan:
- Program slot0=08:00 with counts {2,1}. Drive the time to 07:59:59, then tick → req[0] handshakes twice, then req[1] once, then alarm=1. A taken_ack drops alarm the next cycle; missed_cnt=0.
- Slot1=12:30 enabled, counts {0,0}. At 12:30:00 → no req; alarm asserts. No ack for 900 ticks → alarm drops, missed_cnt=1.
- Slots 0 and 2 both set to 20:00 with different counts → only slot0's counts are dispensed.
- A trigger at 09:00 while still in ALARM from 08:59 → pending is set. After ack, the 09:00 dose dispenses with no new time match.
- Assert reset while req[1] is high mid-handshake → req=0, alarm=0 the next cycle, and the table is cleared (08:00 no longer fires).
- taken_ack on the same cycle the timeout expires → missed_cnt unchanged. With DOSE_MISS_CNT_EN undefined, missed_cnt stays 0 throughout.

Source files
------------

// File: rtl/dose_pkg.sv
// Shared types, field widths and width helpers for the dose scheduler.
package dose_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      ALARM    = 2'd2
   } state_e;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam int MISS_W = 8;

   // Width of the alarm timer so it can hold the full timeout value.
   function automatic int tmr_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dose_scheduler_if.sv
// Dispenser/alarm handshake bundle between the scheduler (master) and the
// compartment drivers plus alarm block (slave).
interface dose_scheduler_if #(
   parameter int NUM_CH = 2
) ();
   import dose_pkg::*;

   logic [NUM_CH-1:0] dispense_req;
   logic [NUM_CH-1:0] dispense_ack;
   logic              alarm;
   logic              taken_ack;
   logic              busy;
   logic [MISS_W-1:0] missed_cnt;

   modport master (
      output dispense_req, alarm, busy, missed_cnt,
      input  dispense_ack, taken_ack
   );

   modport slave (
      input  dispense_req, alarm, busy, missed_cnt,
      output dispense_ack, taken_ack
   );

endinterface

// File: rtl/dose_slot_match.sv
// Priority compare of the dose table against the current hour/minute;
// the lowest-index enabled, in-range, matching slot wins.
module dose_slot_match
   import dose_pkg::*;
#(
   parameter  int NUM_SLOTS = 3,
   localparam int SLOT_W    = idx_w(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] en_i,
   input  logic [HOUR_W-1:0]    hour_i [NUM_SLOTS],
   input  logic [MIN_W-1:0]     min_i  [NUM_SLOTS],
   input  logic [HOUR_W-1:0]    hours_i,
   input  logic [MIN_W-1:0]     minutes_i,
   output logic                 hit_o,
   output logic [SLOT_W-1:0]    idx_o
);

   logic [NUM_SLOTS-1:0] match_s;

   // Out-of-range table entries are excluded so they can never fire.
   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         match_s[s] = en_i[s] && (hour_i[s] < HOUR_W'(24)) && (min_i[s] < MIN_W'(60)) &&
                      (hour_i[s] == hours_i) && (min_i[s] == minutes_i);
      end
   end

   assign hit_o = |match_s;

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      idx_o = {SLOT_W{1'b0}};
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         idx_o = match_s[s] ? SLOT_W'(s) : idx_o;
      end
   end

endmodule

// File: rtl/dose_scheduler.sv
// Programmable dose table, per-channel dispense sequencing and acknowledge alarm.
// Define DOSE_MISS_CNT_EN to build the saturating missed-dose counter.
module dose_scheduler
   import dose_pkg::*;
#(
   parameter  int NUM_CH        = 2,
   parameter  int NUM_SLOTS     = 3,
   parameter  int CNT_W         = 3,
   parameter  int ACK_TIMEOUT_S = 900,
   localparam int SLOT_W        = idx_w(NUM_SLOTS),
   localparam int CH_W          = idx_w(NUM_CH),
   localparam int TMR_W         = tmr_w(ACK_TIMEOUT_S)
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              tick_sec,
   input  logic [HOUR_W-1:0] hours,
   input  logic [MIN_W-1:0]  minutes,
   input  logic [SEC_W-1:0]  seconds,
   input  logic              cfg_we,
   input  logic [SLOT_W-1:0] cfg_slot,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic              cfg_en,
   input  logic [HOUR_W-1:0] cfg_hour,
   input  logic [MIN_W-1:0]  cfg_min,
   input  logic [CNT_W-1:0]  cfg_count,
   dose_scheduler_if.master  dsp
);

   logic [NUM_SLOTS-1:0] en_q;
   logic [HOUR_W-1:0]    hour_q [NUM_SLOTS];
   logic [MIN_W-1:0]     min_q  [NUM_SLOTS];
   logic [CNT_W-1:0]     cnt_q  [NUM_SLOTS][NUM_CH];

   state_e            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CNT_W-1:0]  rem_q [NUM_CH];
   logic [CNT_W-1:0]  rem_d [NUM_CH];
   logic [NUM_CH-1:0] req_q, req_d;
   logic              alarm_q, alarm_d;
   logic              busy_q, busy_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              pend_q, pend_d;
   logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;
   logic              hit_s, trig_s, miss_s;
   logic [SLOT_W-1:0] hit_idx_s;

   dose_slot_match #(.NUM_SLOTS(NUM_SLOTS)) u_match (
      .en_i      (en_q),
      .hour_i    (hour_q),
      .min_i     (min_q),
      .hours_i   (hours),
      .minutes_i (minutes),
      .hit_o     (hit_s),
      .idx_o     (hit_idx_s)
   );

   assign trig_s = tick_sec && (seconds == {SEC_W{1'b0}}) && hit_s;

   // Dose table; writes land in any state and only affect later triggers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         en_q <= {NUM_SLOTS{1'b0}};
         for (int s = 0; s < NUM_SLOTS; s++) begin
            hour_q[s] <= {HOUR_W{1'b0}};
            min_q[s]  <= {MIN_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
               cnt_q[s][c] <= {CNT_W{1'b0}};
            end
         end
      end else if (cfg_we && (int'(cfg_slot) < NUM_SLOTS)) begin
         en_q[cfg_slot]   <= cfg_en;
         hour_q[cfg_slot] <= cfg_hour;
         min_q[cfg_slot]  <= cfg_min;
         if (int'(cfg_ch) < NUM_CH) begin
            cnt_q[cfg_slot][cfg_ch] <= cfg_count;
         end
      end
   end

   // Next-state, pending queue and handshake sequencing.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      rem_d       = rem_q;
      req_d       = req_q;
      tmr_d       = tmr_q;
      pend_slot_d = pend_slot_q;
      miss_s      = 1'b0;
      if ((state_q != IDLE) && trig_s && !pend_q) begin
         pend_d      = 1'b1;
         pend_slot_d = hit_idx_s;
      end else begin
         pend_d = pend_q;
      end
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               rem_d       = cnt_q[pend_slot_q];
               ch_d        = {CH_W{1'b0}};
               state_d     = DISPENSE;
               pend_d      = trig_s;
               pend_slot_d = hit_idx_s;
            end else if (trig_s) begin
               rem_d   = cnt_q[hit_idx_s];
               ch_d    = {CH_W{1'b0}};
               state_d = DISPENSE;
            end else begin
               state_d = IDLE;
            end
         end
         DISPENSE: begin
            // req drops after each ack and is re-evaluated a cycle later, giving the low gap.
            if (req_q[ch_q]) begin
               if (dsp.dispense_ack[ch_q]) begin
                  rem_d[ch_q] = rem_q[ch_q] - CNT_W'(1);
                  req_d       = {NUM_CH{1'b0}};
               end else begin
                  req_d = req_q;
               end
            end else if (rem_q[ch_q] != {CNT_W{1'b0}}) begin
               req_d = NUM_CH'(1) << ch_q;
            end else if (ch_q == CH_W'(NUM_CH - 1)) begin
               state_d = ALARM;
               tmr_d   = {TMR_W{1'b0}};
            end else begin
               ch_d = ch_q + CH_W'(1);
            end
         end
         ALARM: begin
            if (dsp.taken_ack) begin
               state_d = IDLE;
            end else if (tick_sec && (tmr_q == TMR_W'(ACK_TIMEOUT_S - 1))) begin
               state_d = IDLE;
               miss_s  = 1'b1;
            end else if (tick_sec) begin
               tmr_d = tmr_q + TMR_W'(1);
            end else begin
               tmr_d = tmr_q;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = {NUM_CH{1'b0}};
         end
      endcase
      alarm_d = (state_d == ALARM);
      busy_d  = (state_d != IDLE);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= IDLE;
         ch_q        <= {CH_W{1'b0}};
         for (int c = 0; c < NUM_CH; c++) begin
            rem_q[c] <= {CNT_W{1'b0}};
         end
         req_q       <= {NUM_CH{1'b0}};
         alarm_q     <= 1'b0;
         busy_q      <= 1'b0;
         tmr_q       <= {TMR_W{1'b0}};
         pend_q      <= 1'b0;
         pend_slot_q <= {SLOT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         rem_q       <= rem_d;
         req_q       <= req_d;
         alarm_q     <= alarm_d;
         busy_q      <= busy_d;
         tmr_q       <= tmr_d;
         pend_q      <= pend_d;
         pend_slot_q <= pend_slot_d;
      end
   end

`ifdef DOSE_MISS_CNT_EN
   logic [MISS_W-1:0] missed_q;

   // Saturating count of alarms that timed out without acknowledge.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         missed_q <= {MISS_W{1'b0}};
      end else if (miss_s && (missed_q != {MISS_W{1'b1}})) begin
         missed_q <= missed_q + MISS_W'(1);
      end
   end

   assign dsp.missed_cnt = missed_q;
`else
   logic miss_unused_s;
   assign miss_unused_s  = miss_s;
   assign dsp.missed_cnt = {MISS_W{1'b0}};
`endif

   assign dsp.dispense_req = req_q;
   assign dsp.alarm        = alarm_q;
   assign dsp.busy         = busy_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed and randomized bench for dose_scheduler with a table-level reference model.
module tb_dose_scheduler;

   localparam int NUM_CH = 2;
   localparam int NUM_SLOTS = 3;
   localparam int CNT_W = 3;
   localparam int TMO = 900;
`ifdef DOSE_MISS_CNT_EN
   localparam int MISS_EN = 1;
`else
   localparam int MISS_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       reset, tick_sec, cfg_we, cfg_en;
   logic [4:0] hours, cfg_hour;
   logic [5:0] minutes, seconds, cfg_min;
   logic [1:0] cfg_slot;
   logic [0:0] cfg_ch;
   logic [2:0] cfg_count;

   dose_scheduler_if #(.NUM_CH(NUM_CH)) dsp ();

   dose_scheduler #(.NUM_CH(NUM_CH), .NUM_SLOTS(NUM_SLOTS), .CNT_W(CNT_W), .ACK_TIMEOUT_S(TMO)) dut (
      .CLOCK_50(clk), .reset(reset), .tick_sec(tick_sec), .hours(hours), .minutes(minutes),
      .seconds(seconds), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
      .cfg_hour(cfg_hour), .cfg_min(cfg_min), .cfg_count(cfg_count), .dsp(dsp)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_en [NUM_SLOTS];
   int m_hour [NUM_SLOTS];
   int m_min [NUM_SLOTS];
   int m_cnt [NUM_SLOTS][NUM_CH];
   int exp_missed = 0;
   int pills [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_match(input int h, input int m);
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (m_en[s] != 0 && m_hour[s] < 24 && m_min[s] < 60 && m_hour[s] == h && m_min[s] == m)
            return s;
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NUM_SLOTS; s++) begin
         m_en[s] = 0; m_hour[s] = 0; m_min[s] = 0;
         for (int c = 0; c < NUM_CH; c++) m_cnt[s][c] = 0;
      end
   endtask

   task automatic cfg_write(input int s, input int en, input int h, input int m, input int c0, input int c1);
      for (int c = 0; c < NUM_CH; c++) begin
         @(negedge clk);
         cfg_we = 1'b1; cfg_slot = 2'(s); cfg_ch = 1'(c); cfg_en = 1'(en);
         cfg_hour = 5'(h); cfg_min = 6'(m); cfg_count = 3'((c == 0) ? c0 : c1);
      end
      @(negedge clk);
      cfg_we = 1'b0;
      m_en[s] = en; m_hour[s] = h; m_min[s] = m; m_cnt[s][0] = c0; m_cnt[s][1] = c1;
   endtask

   task automatic tick(input int h, input int m, input int s, input bit ack = 1'b0);
      @(negedge clk);
      hours = 5'(h); minutes = 6'(m); seconds = 6'(s); tick_sec = 1'b1; dsp.taken_ack = ack;
      @(negedge clk);
      tick_sec = 1'b0; dsp.taken_ack = 1'b0;
   endtask

   // Act as the compartment drivers until the alarm rises, then compare pill order.
   task automatic serve(input int slot, input string tag);
      bit ack_on = 1'b0;
      bit saw_alarm = 1'b0;
      int dly = $urandom_range(0, 2);
      int gap_bad = 0;
      int onehot_bad = 0;
      int exp_q [$];
      pills.delete();
      for (int cyc = 0; cyc < 300 && !saw_alarm; cyc++) begin
         @(negedge clk);
         if (ack_on) begin
            if (dsp.dispense_req != '0) gap_bad++;
            dsp.dispense_ack = '0;
            ack_on = 1'b0;
         end else if (dsp.alarm) begin
            saw_alarm = 1'b1;
         end else if (dsp.dispense_req != '0) begin
            if ($countones(dsp.dispense_req) != 1) onehot_bad++;
            if (dly == 0) begin
               for (int c = NUM_CH - 1; c >= 0; c--) if (dsp.dispense_req[c]) dly = c;
               pills.push_back(dly);
               dsp.dispense_ack = dsp.dispense_req;
               ack_on = 1'b1;
               dly = $urandom_range(0, 2);
            end else begin
               dly--;
            end
         end
      end
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < m_cnt[slot][c]; k++) exp_q.push_back(c);
      chk({tag, "_alarm"}, 32'(saw_alarm), 32'd1);
      chk({tag, "_gap"}, 32'(gap_bad), 32'd0);
      chk({tag, "_onehot"}, 32'(onehot_bad), 32'd0);
      chk({tag, "_npills"}, 32'(pills.size()), 32'(exp_q.size()));
      for (int i = 0; i < pills.size() && i < exp_q.size(); i++)
         chk({tag, "_pillch"}, 32'(pills[i]), 32'(exp_q[i]));
   endtask

   task automatic give_ack(input string tag);
      @(negedge clk);
      dsp.taken_ack = 1'b1;
      @(negedge clk);
      dsp.taken_ack = 1'b0;
      chk({tag, "_alarm_off"}, 32'(dsp.alarm), 32'd0);
      chk({tag, "_busy_off"}, 32'(dsp.busy), 32'd0);
      chk({tag, "_missed"}, 32'(dsp.missed_cnt), 32'(exp_missed));
   endtask

   initial begin
      int s, en, h, m, qh, qm, exp_slot;
      bit found;
      reset = 1'b1; tick_sec = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0; cfg_slot = '0; cfg_ch = '0;
      cfg_hour = '0; cfg_min = '0; cfg_count = '0; hours = '0; minutes = '0; seconds = '0;
      dsp.dispense_ack = '0; dsp.taken_ack = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(dsp.dispense_req), 32'd0);
      chk("rst_alarm", 32'(dsp.alarm), 32'd0);
      chk("rst_busy", 32'(dsp.busy), 32'd0);
      chk("rst_missed", 32'(dsp.missed_cnt), 32'd0);
      reset = 1'b0;
      tick(0, 0, 0);
      chk("empty_table_idle", 32'(dsp.busy), 32'd0);

      // Basic dose with trigger-to-request latency.
      cfg_write(0, 1, 8, 0, 2, 1);
      tick(7, 59, 59);
      chk("pre_time_idle", 32'(dsp.busy), 32'd0);
      tick(8, 0, 0);
      chk("lat_busy", 32'(dsp.busy), 32'd1);
      chk("lat_req_t1", 32'(dsp.dispense_req), 32'd0);
      @(negedge clk);
      chk("lat_req_t2", 32'(dsp.dispense_req), 32'd1);
      serve(0, "t1");
      give_ack("t1");

      // All-zero counts, then alarm timeout.
      cfg_write(1, 1, 12, 30, 0, 0);
      tick(12, 30, 0);
      serve(1, "t2");
      for (int i = 1; i < TMO; i++) tick(12, 30, 1 + (i % 59));
      chk("tmo_alarm_hold", 32'(dsp.alarm), 32'd1);
      tick(12, 31, 5);
      exp_missed += MISS_EN;
      chk("tmo_alarm_off", 32'(dsp.alarm), 32'd0);
      chk("tmo_busy_off", 32'(dsp.busy), 32'd0);
      chk("tmo_missed", 32'(dsp.missed_cnt), 32'(exp_missed));

      // Two slots at the same time: lowest index wins.
      cfg_write(0, 1, 20, 0, 1, 2);
      cfg_write(2, 1, 20, 0, 3, 0);
      tick(20, 0, 0);
      serve(model_match(20, 0), "prio");
      give_ack("prio");

      // Trigger during alarm is held one deep; a repeat is dropped.
      cfg_write(0, 1, 8, 59, 1, 0);
      cfg_write(2, 1, 9, 0, 0, 2);
      tick(8, 59, 0);
      serve(0, "p1");
      tick(9, 0, 0);
      tick(9, 0, 0);
      chk("pend_alarm_hold", 32'(dsp.alarm), 32'd1);
      give_ack("p1");
      serve(2, "p2");
      give_ack("p2");
      repeat (4) @(negedge clk);
      chk("pend_one_deep", 32'(dsp.busy), 32'd0);

      // Acknowledge coincident with the timeout.
      tick(12, 30, 0);
      serve(1, "t6");
      for (int i = 1; i < TMO; i++) tick(12, 30, 1 + (i % 59));
      tick(12, 31, 5, 1'b1);
      chk("tie_alarm_off", 32'(dsp.alarm), 32'd0);
      chk("tie_missed", 32'(dsp.missed_cnt), 32'(exp_missed));

      // Reset in the middle of a channel 1 handshake.
      cfg_write(0, 1, 8, 0, 0, 2);
      tick(8, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         found = (dsp.dispense_req == 2'b10);
      end
      chk("mid_req1_seen", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      exp_missed = 0;
      chk("mid_rst_req", 32'(dsp.dispense_req), 32'd0);
      chk("mid_rst_alarm", 32'(dsp.alarm), 32'd0);
      chk("mid_rst_missed", 32'(dsp.missed_cnt), 32'd0);
      tick(8, 0, 0);
      @(negedge clk);
      chk("cleared_no_fire", 32'(dsp.busy), 32'd0);
      chk("cleared_no_req", 32'(dsp.dispense_req), 32'd0);

      // Randomized table programming and time queries.
      for (int it = 0; it < 30; it++) begin
         s  = $urandom_range(0, NUM_SLOTS - 1);
         en = ($urandom_range(0, 3) != 0) ? 1 : 0;
         h  = $urandom_range(0, 25);
         m  = $urandom_range(0, 62);
         cfg_write(s, en, h, m, $urandom_range(0, 7), $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            qh = h; qm = m;
         end else begin
            qh = $urandom_range(0, 25); qm = $urandom_range(0, 62);
         end
         exp_slot = model_match(qh, qm);
         tick(qh, qm, 0);
         if (exp_slot >= 0) begin
            serve(exp_slot, "rnd");
            give_ack("rnd");
         end else begin
            @(negedge clk);
            chk("rnd_no_fire", 32'(dsp.busy), 32'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
